inst_dispatch_stage: RTL and testbench

- Sits directly downstream of the in-order instruction queue and is the front of the OoO backend.
- Pulls up to 4 micro-ops per read from the queue into a 4-entry holding buffer.
- Dispatches them strictly in program order to per-functional-unit valid/ready ports, at most one uop per unit per cycle and at most 4 per cycle.
- Only refills from the queue once its buffer has fully drained.

---
 rtl/inst_dispatch_stage_pkg.sv | 19 +
 rtl/inst_dispatch_stage_dispatch_select.sv | 39 +++
 rtl/inst_dispatch_stage.sv | 149 ++++++++++++++
 tb/tb_inst_dispatch_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_dispatch_stage_pkg.sv
// Shared definitions for inst_dispatch_stage: FSM encodings, slot count,
// unit-code sizing and the count-1 decode helper.
package inst_dispatch_stage_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam int SLOT_COUNT   = 4;
   localparam int FU_CODE_SIZE = 3;
   localparam int NUM_FU       = 2**FU_CODE_SIZE;

   // Queue reports count-1 on two bits; decode to 1..4.
   function automatic logic [2:0] countFromCode(input logic [1:0] code);
      return {1'b0, code} + 3'd1;
   endfunction

endpackage

// File: rtl/inst_dispatch_stage_dispatch_select.sv
// In-order prefix selector: offers each entry to its unit while all older
// entries were accepted, and reports which entries were actually accepted.
module dispatch_select
   import inst_dispatch_stage_pkg::*;
#(
   parameter int funcUnitCodeSize = FU_CODE_SIZE,
   localparam int numFuncUnits = 2**funcUnitCodeSize
) (
   input  logic [SLOT_COUNT-1:0]                       entryValid,
   input  logic [SLOT_COUNT-1:0][funcUnitCodeSize-1:0] entryUnit,
   input  logic [numFuncUnits-1:0]                     fuReady,
   output logic [SLOT_COUNT-1:0]                       offerMask,
   output logic [SLOT_COUNT-1:0]                       selMask,
   output logic [2:0]                                  selCount
);

   logic prefixOk;
   logic dupUnit;

   // An entry is offered without looking at its own unit's ready, so the
   // valid never depends combinationally on the matching ready.
   always_comb begin
      offerMask = '0;
      selMask   = '0;
      selCount  = '0;
      prefixOk  = 1'b1;
      dupUnit   = 1'b0;
      for (int k = 0; k < SLOT_COUNT; k++) begin
         dupUnit = 1'b0;
         for (int j = 0; j < k; j++)
            if (entryUnit[j] == entryUnit[k]) dupUnit = 1'b1;
         offerMask[k] = prefixOk && entryValid[k] && !dupUnit;
         selMask[k]   = offerMask[k] && fuReady[entryUnit[k]];
         prefixOk     = selMask[k];
         selCount     = selCount + {2'b00, selMask[k]};
      end
   end

endmodule

// File: rtl/inst_dispatch_stage.sv
// Dispatch stage: fetches up to 4 uops from the instruction queue, then issues
// them in order to per-unit valid/ready ports. Optional stats: DISPATCH_STATS_EN.
module inst_dispatch_stage
   import inst_dispatch_stage_pkg::*;
#(
   parameter int funcUnitCodeSize = FU_CODE_SIZE,
   parameter int payloadWidth     = 128,
   localparam int numFuncUnits    = 2**funcUnitCodeSize
) (
   input  logic                                   clock_i,
   input  logic                                   reset_i,
   input  logic                                   flush_i,
   output logic                                   readEnable_o,
   input  logic                                   queueValid_i,
   input  logic [1:0]                             numInstructions_i,
   input  logic [SLOT_COUNT*funcUnitCodeSize-1:0] funcUnits_i,
   input  logic [SLOT_COUNT*payloadWidth-1:0]     payloads_i,
   output logic [numFuncUnits-1:0]                fuValid_o,
   input  logic [numFuncUnits-1:0]                fuReady_i,
   output logic [numFuncUnits*payloadWidth-1:0]   fuPayload_o,
   output logic [2:0]                             bufCount_o,
   output logic                                   busy_o
`ifdef DISPATCH_STATS_EN
  ,output logic [31:0]                            dispatchedCount_o,
   output logic [31:0]                            stallCycles_o
`endif
);

   logic [1:0]                  state;
   logic [1:0]                  head;
   logic [2:0]                  count;
   logic [funcUnitCodeSize-1:0] bufUnit    [SLOT_COUNT];
   logic [payloadWidth-1:0]     bufPayload [SLOT_COUNT];

   logic                                       draining;
   logic [1:0]                                 slotIdx;
   logic [SLOT_COUNT-1:0]                      entryValid;
   logic [SLOT_COUNT-1:0]                      offerMask;
   logic [SLOT_COUNT-1:0]                      selMask;
   logic [SLOT_COUNT-1:0][funcUnitCodeSize-1:0] entryUnit;
   logic [SLOT_COUNT-1:0][payloadWidth-1:0]     entryPayload;
   logic [2:0]                                 selCount;
   logic                                       drained;
   logic [numFuncUnits-1:0][payloadWidth-1:0]  unitPayload;

   assign draining = (state == ST_DRAIN) && !flush_i;

   // Present the live entries oldest-first starting at head.
   always_comb begin
      entryValid   = '0;
      entryUnit    = '0;
      entryPayload = '0;
      slotIdx      = '0;
      for (int i = 0; i < SLOT_COUNT; i++) begin
         slotIdx         = head + 2'(i);
         entryValid[i]   = draining && (3'(i) < count);
         entryUnit[i]    = bufUnit[slotIdx];
         entryPayload[i] = bufPayload[slotIdx];
      end
   end

   dispatch_select #(.funcUnitCodeSize(funcUnitCodeSize)) uSelect (
      .entryValid (entryValid),
      .entryUnit  (entryUnit),
      .fuReady    (fuReady_i),
      .offerMask  (offerMask),
      .selMask    (selMask),
      .selCount   (selCount)
   );

   assign drained = (selMask == entryValid);

   always_comb begin
      fuValid_o   = '0;
      unitPayload = '0;
      for (int k = 0; k < SLOT_COUNT; k++) begin
         if (offerMask[k]) begin
            fuValid_o[entryUnit[k]]   = 1'b1;
            unitPayload[entryUnit[k]] = entryPayload[k];
         end
      end
   end

   assign fuPayload_o  = unitPayload;
   assign readEnable_o = (state == ST_REQ);
   assign bufCount_o   = count;
   assign busy_o       = (state != ST_IDLE) || (count != 3'd0);

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= ST_IDLE;
         head  <= '0;
         count <= '0;
         for (int i = 0; i < SLOT_COUNT; i++) begin
            bufUnit[i]    <= '0;
            bufPayload[i] <= '0;
         end
      end else if (flush_i) begin
         state <= ST_IDLE;
         head  <= '0;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ:  state <= ST_WAIT;
            ST_WAIT: begin
               if (queueValid_i) begin
                  // Slot 0 sits in the MSBs of the queue bus.
                  for (int i = 0; i < SLOT_COUNT; i++) begin
                     bufUnit[i]    <= funcUnits_i[(SLOT_COUNT-1-i)*funcUnitCodeSize +: funcUnitCodeSize];
                     bufPayload[i] <= payloads_i[(SLOT_COUNT-1-i)*payloadWidth +: payloadWidth];
                  end
                  head  <= '0;
                  count <= countFromCode(numInstructions_i);
                  state <= ST_DRAIN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               head  <= head + selCount[1:0];
               count <= count - selCount;
               if (drained) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         dispatchedCount_o <= '0;
         stallCycles_o     <= '0;
      end else if (flush_i) begin
         dispatchedCount_o <= '0;
         stallCycles_o     <= '0;
      end else begin
         if (dispatchedCount_o > (32'hFFFF_FFFF - 32'(selCount)))
            dispatchedCount_o <= '1;
         else
            dispatchedCount_o <= dispatchedCount_o + 32'(selCount);
         if ((state == ST_DRAIN) && (selCount == 3'd0) && (stallCycles_o != '1))
            stallCycles_o <= stallCycles_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_dispatch_stage.sv
// Bench for inst_dispatch_stage: directed and randomized fetch/drain sequences
// checked against an in-order uop list model.
module tb_inst_dispatch_stage;

   localparam int PW = 128;

   logic            clock_i = 1'b0;
   logic            reset_i = 1'b0;
   logic            flush_i = 1'b0;
   logic            queueValid_i = 1'b0;
   logic [1:0]      numInstructions_i = '0;
   logic [11:0]     funcUnits_i = '0;
   logic [4*PW-1:0] payloads_i = '0;
   logic [7:0]      fuReady_i = '0;
   logic            readEnable_o;
   logic            busy_o;
   logic [7:0]      fuValid_o;
   logic [8*PW-1:0] fuPayload_o;
   logic [2:0]      bufCount_o;
`ifdef DISPATCH_STATS_EN
   logic [31:0]     dispatchedCount;
   logic [31:0]     stallCycles;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]    unit;
      logic [PW-1:0] pl;
   } uop_t;
   uop_t model[$];

   inst_dispatch_stage dut (
      .clock_i           (clock_i),
      .reset_i           (reset_i),
      .flush_i           (flush_i),
      .readEnable_o      (readEnable_o),
      .queueValid_i      (queueValid_i),
      .numInstructions_i (numInstructions_i),
      .funcUnits_i       (funcUnits_i),
      .payloads_i        (payloads_i),
      .fuValid_o         (fuValid_o),
      .fuReady_i         (fuReady_i),
      .fuPayload_o       (fuPayload_o),
      .bufCount_o        (bufCount_o),
`ifdef DISPATCH_STATS_EN
      .dispatchedCount_o (dispatchedCount),
      .stallCycles_o     (stallCycles),
`endif
      .busy_o            (busy_o)
   );

   always #5 clock_i = ~clock_i;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] rndPayload();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chkIdleOutputs(input string tag);
      chk({tag, ".valid"}, fuValid_o, 0);
      chk({tag, ".count"}, bufCount_o, 0);
      chk({tag, ".busy"}, busy_o, 0);
      chk({tag, ".re"}, readEnable_o, 0);
   endtask

   // Counts negedges until readEnable_o is seen, bounded.
   task automatic waitReq(input int expCycles, input string tag);
      int n = 0;
      do begin
         @(negedge clock_i);
         n++;
      end while (!readEnable_o && n < 10);
      chk(tag, n, expCycles);
   endtask

   // mode 0: all ready; 1: random ready; 2: unit 3 stalled for the first 3 cycles.
   task automatic drain(input int mode, input int abortAt, input bit abortIsReset);
      int            cyc = 0;
      int            acc;
      logic [7:0]    used;
      logic [7:0]    expV;
      logic [PW-1:0] expP [8];
      while (model.size() != 0 && cyc < 64) begin
         case (mode)
            0:       fuReady_i = 8'hFF;
            1:       for (int u = 0; u < 8; u++) fuReady_i[u] = ($urandom % 4) != 0;
            default: fuReady_i = (cyc < 3) ? 8'hF7 : 8'hFF;
         endcase
         queueValid_i = 1'($urandom);
         if (cyc == abortAt && !abortIsReset) flush_i = 1'b1;
         @(negedge clock_i);
         if (cyc == abortAt && abortIsReset) begin
            chk("rst.countBefore", bufCount_o, model.size());
            reset_i = 1'b0;
            #1;
            chkIdleOutputs("rst");
            for (int u = 0; u < 8; u++) chk("rst.payload", fuPayload_o[u*PW +: PW], 0);
            model.delete();
            queueValid_i = 1'b0;
            fuReady_i = 8'hFF;
            @(posedge clock_i); #1;
            reset_i = 1'b1;
            return;
         end
         expV = '0;
         used = '0;
         acc  = 0;
         for (int u = 0; u < 8; u++) expP[u] = '0;
         if (!flush_i) begin
            foreach (model[i]) begin
               if (used[model[i].unit]) break;
               used[model[i].unit] = 1'b1;
               expV[model[i].unit] = 1'b1;
               expP[model[i].unit] = model[i].pl;
               if (!fuReady_i[model[i].unit]) break;
               acc++;
            end
         end
         chk("drain.valid", fuValid_o, expV);
         chk("drain.count", bufCount_o, model.size());
         chk("drain.busy", busy_o, 1);
         chk("drain.re", readEnable_o, 0);
         for (int u = 0; u < 8; u++) chk("drain.payload", fuPayload_o[u*PW +: PW], expP[u]);
         if (flush_i) model.delete();
         else repeat (acc) void'(model.pop_front());
         @(posedge clock_i); #1;
         flush_i = 1'b0;
         cyc++;
      end
      chk("drain.timeout", model.size(), 0);
      queueValid_i = 1'b0;
      @(negedge clock_i);
      chkIdleOutputs("post");
   endtask

   task automatic runTxn(input int n, input logic [11:0] us, input int mode,
                         input int abortAt, input bit abortIsReset, input int expWait);
      logic [PW-1:0] pl;
      waitReq(expWait, "req.timing");
      @(posedge clock_i); #1;
      queueValid_i      = 1'b1;
      numInstructions_i = 2'(n - 1);
      funcUnits_i       = us;
      for (int s = 0; s < 4; s++) begin
         pl = rndPayload();
         payloads_i[(3-s)*PW +: PW] = pl;
         if (s < n) model.push_back('{us[(3-s)*3 +: 3], pl});
      end
      @(negedge clock_i);
      chk("wait.re", readEnable_o, 0);
      chk("wait.valid", fuValid_o, 0);
      chk("wait.busy", busy_o, 1);
      @(posedge clock_i); #1;
      queueValid_i = 1'b0;
      drain(mode, abortAt, abortIsReset);
   endtask

   initial begin
      logic [11:0] us;
      fuReady_i = 8'hFF;
      repeat (2) @(negedge clock_i);
      chkIdleOutputs("reset");
      chk("reset.payload", fuPayload_o[PW-1:0], 0);
      @(posedge clock_i); #1;
      reset_i = 1'b1;

      // All four units distinct and ready: one drain cycle.
      runTxn(4, {3'd0, 3'd1, 3'd2, 3'd3}, 0, -1, 1'b0, 2);
      // Same unit four times: one per cycle.
      runTxn(4, {3'd5, 3'd5, 3'd5, 3'd5}, 0, -1, 1'b0, 1);
      // Unit 3 stalled: younger ready entries must wait.
      runTxn(4, {3'd2, 3'd3, 3'd2, 3'd4}, 2, -1, 1'b0, 1);

      // Empty queue response returns to IDLE and re-requests.
      waitReq(1, "empty.req");
      @(posedge clock_i); #1;
      queueValid_i = 1'b0;
      funcUnits_i  = 12'($urandom);
      @(negedge clock_i);
      chk("empty.waitBusy", busy_o, 1);
      @(posedge clock_i); #1;
      @(negedge clock_i);
      chkIdleOutputs("empty.idle");

      // Flush in WAIT with a live response: response dropped.
      waitReq(1, "flushWait.req");
      @(posedge clock_i); #1;
      queueValid_i      = 1'b1;
      numInstructions_i = 2'b01;
      funcUnits_i       = {3'd1, 3'd2, 3'd3, 3'd4};
      flush_i           = 1'b1;
      @(negedge clock_i);
      chk("flushWait.valid", fuValid_o, 0);
      @(posedge clock_i); #1;
      flush_i = 1'b0;
      @(negedge clock_i);
      chkIdleOutputs("flushWait.idle");
      queueValid_i = 1'b0;

      // Flush mid-drain.
      runTxn(4, {3'd5, 3'd5, 3'd5, 3'd5}, 0, 2, 1'b0, 1);
      // Reset mid-drain with three entries left.
      runTxn(4, {3'd2, 3'd3, 3'd2, 3'd4}, 2, 1, 1'b1, 1);

      // Randomized traffic; narrow unit range half the time to force conflicts.
      for (int t = 0; t < 24; t++) begin
         for (int s = 0; s < 4; s++)
            us[s*3 +: 3] = (t % 2 == 0) ? 3'($urandom % 3) : 3'($urandom % 8);
         runTxn(1 + int'($urandom % 4), us, 1, -1, 1'b0, (t == 0) ? 2 : 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
